mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle control FSM that sequences the shared MIPS datapath (single ALU, single unified memory port, IR, A/B/ALUOut registers) through fetch, decode, execute, memory and write-back steps. Replaces the single-cycle opcode decoder when the core runs in multi-cycle mode. Stalls on a memory-ready handshake and emits per-state datapath strobes plus a 3-bit ALU operation code in the existing `aluOp` encoding.

## Interface
- OPCODE_WIDTH, 6, instruction opcode field width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  OPCODE_WIDTH  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  load PC
- ir_write  out  1  load IR from memory data
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1 each  memory request strobes
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  out  3  000 = add, 001 = sub, 010 = decode funct
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  sticky, set on unsupported opcode
- state  out  4  current state code (debug)

## Operation
- States (code): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11, TRAP 12.
- Outputs are Moore-decoded from the state. Every strobe not listed for a state is 0; select fields not listed are 0.
- FETCH:
  - asserts mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - asserts ir_write and pc_write only in a cycle with mem_ready=1, then goes to DECODE; otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 / 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000 -> ADDI_EXEC
  - 000010 -> JUMP
  - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1, instr_done. Next FETCH.
- MEM_WR: mem_write, i_or_d=1. Holds until mem_ready; in the mem_ready cycle asserts instr_done, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Next R_WB.
- R_WB: reg_write, reg_dst=1, mem_to_reg=0, instr_done. Next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01.
  - pc_write = zero.
  - instr_done. Next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000. Next ADDI_WB.
- ADDI_WB: reg_write, reg_dst=0, mem_to_reg=0, instr_done. Next FETCH.
- JUMP: pc_write, pc_source=10, instr_done. Next FETCH.
- TRAP: all strobes 0 and illegal=1. Absorbing state; exits only via reset.

## Timing
- Reset:
  - rst_n low immediately forces state=FETCH and illegal=0.
  - All strobes are forced to 0 while rst_n=0, independent of mem_ready.
  - After release, the first rising edge is a normal FETCH cycle.
- Reset mid-instruction, including during a memory wait, abandons the instruction. No reg_write or pc_write is issued after reset asserts.
- Latency with zero wait states (mem_ready tied 1), FETCH to final cycle inclusive:
  - beq, j: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Request strobes stay asserted and stable throughout the wait.
- mem_ready is ignored in all other states.
- opcode is sampled only in DECODE. zero is sampled only in BRANCH.
- instr_done is high for exactly one cycle per instruction and never high in FETCH, DECODE or TRAP.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1 -> state=0, all strobes 0, illegal=0. Release -> next cycle mem_read=1, ir_write=1, pc_write=1.
- R-type, mem_ready=1, opcode=000000 -> states 0,1,6,7,0. alu_op=010 in R_EXEC; reg_write=1 and reg_dst=1 in R_WB; instr_done high only in R_WB.
- lw with 2 wait cycles in MEM_RD, opcode=100011 -> states 0,1,2,3,3,3,4,0. mem_read and i_or_d=1 steady for all three MEM_RD cycles; reg_write with mem_to_reg=1 in MEM_WB.
- beq, opcode=000100: zero=1 -> pc_write=1 with pc_source=01 in BRANCH; zero=0 -> pc_write=0. Both cases take 3 cycles.
- Illegal opcode 111111 -> TRAP (12), illegal=1, no further strobes for 20 cycles. Pulse rst_n low -> illegal=0, state=0.
- Async reset asserted mid-cycle during MEM_WR wait, opcode=101011 -> mem_write drops to 0 immediately without a clock edge, and state=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath and emits Moore-decoded datapath strobes per state.
module mips_multicycle_ctrl #(
    parameter int OPCODE_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    ir_write,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    reg_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [2:0]              alu_op,
    output logic [1:0]              pc_source,
    output logic                    instr_done,
    output logic                    illegal,
    output logic [3:0]              state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'b000000);
    localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'b100011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'b101011);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'b000100);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'b001000);
    localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'b000010);

    state_e state_q, state_d;
    logic   is_load_q, is_load_d;
    logic   illegal_q, illegal_d;

    logic       pc_write_s, ir_write_s, i_or_d_s, mem_read_s, mem_write_s;
    logic       reg_write_s, reg_dst_s, mem_to_reg_s, alu_src_a_s, instr_done_s;
    logic [1:0] alu_src_b_s, pc_source_s;
    logic [2:0] alu_op_s;

    // State, load/store flag and sticky illegal flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            is_load_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE, so lw/sw is remembered
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                is_load_d = 1'b0;
                case (opcode)
                    OP_RTYPE: state_d = S_R_EXEC;
                    OP_LW: begin
                        state_d   = S_MEM_ADDR;
                        is_load_d = 1'b1;
                    end
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDI_EXEC;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (is_load_q) state_d = S_MEM_RD;
                else           state_d = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
                else           state_d = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
                else           state_d = S_MEM_WR;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
        if (state_d == S_TRAP) illegal_d = 1'b1;
        else                   illegal_d = illegal_q;
    end

    // Moore decode of datapath controls; mem_ready/zero only qualify strobes
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        i_or_d_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 3'b000;
        pc_source_s  = 2'b00;
        instr_done_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = 2'b01;
                ir_write_s  = mem_ready;
                pc_write_s  = mem_ready;
            end
            S_DECODE:   alu_src_b_s = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_s = 1'b1;
                i_or_d_s   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_s  = 1'b1;
                i_or_d_s     = 1'b1;
                instr_done_s = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = 3'b010;
            end
            S_R_WB: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = 3'b001;
                pc_source_s  = 2'b01;
                pc_write_s   = zero;
                instr_done_s = 1'b1;
            end
            S_ADDI_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_write_s   = 1'b1;
                pc_source_s  = 2'b10;
                instr_done_s = 1'b1;
            end
            S_TRAP:  instr_done_s = 1'b0;
            default: instr_done_s = 1'b0;
        endcase
    end

    // Reset gates every control combinationally so nothing fires before a clock edge
    assign pc_write   = rst_n & pc_write_s;
    assign ir_write   = rst_n & ir_write_s;
    assign i_or_d     = rst_n & i_or_d_s;
    assign mem_read   = rst_n & mem_read_s;
    assign mem_write  = rst_n & mem_write_s;
    assign reg_write  = rst_n & reg_write_s;
    assign reg_dst    = rst_n & reg_dst_s;
    assign mem_to_reg = rst_n & mem_to_reg_s;
    assign alu_src_a  = rst_n & alu_src_a_s;
    assign alu_src_b  = {2{rst_n}} & alu_src_b_s;
    assign alu_op     = {3{rst_n}} & alu_op_s;
    assign pc_source  = {2{rst_n}} & pc_source_s;
    assign instr_done = rst_n & instr_done_s;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the driver queues hand-derived
// expected control vectors, a monitor compares them against the DUT.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done, illegal;
    } outs_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;

    outs_t act;
    outs_t exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    event  chk_ev;

    mips_multicycle_ctrl #(.OPCODE_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign act = '{state, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                   instr_done, illegal};

    // Expected controls for a state, taken directly from the state table
    function automatic outs_t spec_out(input logic [3:0] st, input logic mr, input logic z);
        outs_t o;
        o = '0;
        o.st = st;
        case (st)
            4'd0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            4'd1:  o.alu_src_b = 2'b11;
            4'd2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            4'd3:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
            4'd4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1; end
            4'd5:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = mr; end
            4'd6:  begin o.alu_src_a = 1'b1; o.alu_op = 3'b010; end
            4'd7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1; end
            4'd8:  begin o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_source = 2'b01;
                         o.pc_write = z; o.instr_done = 1'b1; end
            4'd9:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            4'd10: begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
            4'd11: begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1; end
            4'd12: o.illegal = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // One clock cycle of stimulus with the state the DUT must be in during it
    task automatic cyc(input logic mr, input logic z, input logic [5:0] op,
                       input logic [3:0] st, input string tag);
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        exp_q.push_back(spec_out(st, mr, z));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // A cycle spent (or a point reached) with rst_n low: everything must read zero
    task automatic rst_exp(input string tag);
        outs_t o;
        o = '0;
        exp_q.push_back(o);
        tag_q.push_back(tag);
    endtask

    // Monitor: compare the oldest expectation at each sample point
    initial begin
        outs_t e;
        string t;
        forever begin
            @(negedge clk or chk_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h (state got %0d required %0d)",
                             t, act, e, act.st, e.st);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = OP_R;
        @(posedge clk); #1;
        rst_exp("reset_hold0"); @(posedge clk); #1;
        rst_exp("reset_hold1"); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, OP_R, 4'd0, "rtype_fetch");
        cyc(1'b0, 1'b1, OP_R, 4'd1, "rtype_decode");
        cyc(1'b0, 1'b1, OP_R, 4'd6, "rtype_exec");
        cyc(1'b0, 1'b1, OP_R, 4'd7, "rtype_wb");
        // lw with two wait cycles in MEM_RD
        cyc(1'b1, 1'b0, OP_LW, 4'd0, "lw_fetch");
        cyc(1'b1, 1'b0, OP_LW, 4'd1, "lw_decode");
        cyc(1'b1, 1'b0, OP_BAD, 4'd2, "lw_addr");
        cyc(1'b0, 1'b0, OP_BAD, 4'd3, "lw_rd_wait0");
        cyc(1'b0, 1'b0, OP_BAD, 4'd3, "lw_rd_wait1");
        cyc(1'b1, 1'b0, OP_BAD, 4'd3, "lw_rd_done");
        cyc(1'b0, 1'b0, OP_BAD, 4'd4, "lw_wb");
        // beq taken with one fetch wait, then not taken
        cyc(1'b0, 1'b1, OP_BEQ, 4'd0, "beq_fetch_wait");
        cyc(1'b1, 1'b0, OP_BEQ, 4'd0, "beq_fetch");
        cyc(1'b1, 1'b0, OP_BEQ, 4'd1, "beq_decode");
        cyc(1'b1, 1'b1, OP_BEQ, 4'd8, "beq_taken");
        cyc(1'b1, 1'b1, OP_BEQ, 4'd0, "beqn_fetch");
        cyc(1'b1, 1'b1, OP_BEQ, 4'd1, "beqn_decode");
        cyc(1'b1, 1'b0, OP_BEQ, 4'd8, "beq_not_taken");
        // addi and j
        cyc(1'b1, 1'b0, OP_ADDI, 4'd0, "addi_fetch");
        cyc(1'b1, 1'b0, OP_ADDI, 4'd1, "addi_decode");
        cyc(1'b0, 1'b0, OP_ADDI, 4'd9, "addi_exec");
        cyc(1'b1, 1'b0, OP_ADDI, 4'd10, "addi_wb");
        cyc(1'b1, 1'b0, OP_J, 4'd0, "j_fetch");
        cyc(1'b1, 1'b0, OP_J, 4'd1, "j_decode");
        cyc(1'b1, 1'b0, OP_J, 4'd11, "j_jump");
        // sw with one wait cycle in MEM_WR
        cyc(1'b1, 1'b0, OP_SW, 4'd0, "sw_fetch");
        cyc(1'b1, 1'b0, OP_SW, 4'd1, "sw_decode");
        cyc(1'b0, 1'b0, OP_LW, 4'd2, "sw_addr");
        cyc(1'b0, 1'b0, OP_LW, 4'd5, "sw_wr_wait");
        cyc(1'b1, 1'b0, OP_LW, 4'd5, "sw_wr_done");
        // illegal opcode traps until reset
        cyc(1'b1, 1'b0, OP_BAD, 4'd0, "bad_fetch");
        cyc(1'b1, 1'b0, OP_BAD, 4'd1, "bad_decode");
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, OP_R, 4'd12, "trap_hold");
        rst_n = 1'b0;
        rst_exp("trap_reset"); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, OP_SW, 4'd0, "post_trap_fetch");
        // async reset during a MEM_WR wait
        cyc(1'b1, 1'b0, OP_SW, 4'd1, "async_decode");
        cyc(1'b1, 1'b0, OP_SW, 4'd2, "async_addr");
        mem_ready = 1'b0;
        exp_q.push_back(spec_out(4'd5, 1'b0, 1'b0));
        tag_q.push_back("async_wr_wait");
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        rst_exp("async_reset_now");
        -> chk_ev;
        @(posedge clk); #1;
        rst_exp("async_reset_edge"); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, OP_R, 4'd0, "after_async_fetch");
        cyc(1'b1, 1'b0, OP_R, 4'd1, "after_async_decode");
        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
